mtm_alu_cmd_framer: RTL

MTM_ALU_CMD_FRAMER -- requirements
Module: mtm_Alu_cmd_framer

---
 rtl/mtm_alu_pkg.sv | 31 +++
 rtl/mtm_alu_crc4.sv | 27 ++
 rtl/mtm_alu_cmd_framer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mtm_alu_pkg.sv
// rtl/mtm_alu_pkg.sv - shared MTM ALU serial-protocol definitions
//
// Purpose: opcode enum, frame-type bits, frame/packet geometry and the CRC-4
// polynomial used by both the command framer and the ALU-side checker.
// Ports: none (package).
package mtm_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } alu_op_t;

  localparam logic FRAME_DATA = 1'b0;
  localparam logic FRAME_CMD  = 1'b1;

  localparam int FRAME_BITS    = 11;
  localparam int PACKET_FRAMES = 9;
  localparam int CRC_MSG_BITS  = 68;

  // x^4 + x + 1 with the x^4 term implied by the shift-out.
  localparam logic [3:0] CRC4_POLY = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } framer_state_t;

endpackage

// File: rtl/mtm_alu_crc4.sv
// rtl/mtm_alu_crc4.sv - combinational CRC-4 over a 68-bit message
//
// Purpose: CRC-4 (x^4+x+1, init 0000) over {B, A, 1'b1, op}, MSB first.
// Ports:
//   data  in   68  message, bit 67 processed first
//   crc   out   4  resulting remainder
module mtm_alu_crc4
  import mtm_alu_pkg::*;
(
  input  logic [CRC_MSG_BITS-1:0] data,
  output logic [3:0]              crc
);

  function automatic logic [3:0] crc4_calc(input logic [CRC_MSG_BITS-1:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'b0000;
    for (int i = CRC_MSG_BITS - 1; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
    end
    return c;
  endfunction

  assign crc = crc4_calc(data);

endmodule

// File: rtl/mtm_alu_cmd_framer.sv
// rtl/mtm_alu_cmd_framer.sv - serialises an ALU request into the 99-bit MTM packet
//
// Purpose: accepts {A, B, op} and sends 8 data frames (B then A, MSB byte first)
// followed by a CMD frame carrying op and CRC-4, then IDLE_GAP idle bits.
// Ports:
//   clk          in    1  one serial bit per cycle
//   rst_n        in    1  asynchronous active-low reset
//   in_valid     in    1  request present
//   in_ready     out   1  request accepted on this edge if in_valid
//   A, B         in   32  operands
//   op           in    3  opcode, not checked
//   crc_err_inj  in    1  invert transmitted CRC for this request
//   sout         out   1  registered serial line, idle high
//   busy         out   1  packet or idle gap in progress
module mtm_alu_cmd_framer
  import mtm_alu_pkg::*;
#(
  parameter int IDLE_GAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  op,
  input  logic        crc_err_inj,
  output logic        sout,
  output logic        busy
);

  localparam logic [3:0] LAST_BIT   = 4'(FRAME_BITS - 1);
  localparam logic [3:0] LAST_FRAME = 4'(PACKET_FRAMES - 1);
  localparam int         GAP_W      = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  framer_state_t state, state_n;
  logic [3:0]    frame_cnt, frame_n;
  logic [3:0]    bit_cnt, bit_n;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic          sout_n;

  logic [31:0]   a_q, b_q;
  alu_op_t       op_q;
  logic          inj_q;

  logic [3:0]    crc_calc;
  logic [7:0]    cmd_payload;
  logic [7:0]    data_v;
  logic          accept;
  logic          gap_last;

  mtm_alu_crc4 u_crc (
    .data ({b_q, a_q, 1'b1, op_q}),
    .crc  (crc_calc)
  );

  // Gated by rst_n so the output reads 0 while reset is held.
  assign in_ready    = rst_n && (state == ST_IDLE);
  assign accept      = in_valid && in_ready;
  assign busy        = (state != ST_IDLE);
  assign cmd_payload = {1'b0, op_q, crc_calc ^ {4{inj_q}}};
  assign gap_last    = (int'(gap_cnt) == IDLE_GAP - 1);

  always_comb begin
    state_n = state;
    frame_n = frame_cnt;
    bit_n   = bit_cnt;
    gap_n   = gap_cnt;
    sout_n  = 1'b1;
    data_v  = 8'h00;

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_n = ST_SEND;
          frame_n = 4'd0;
          bit_n   = 4'd0;
        end
      end
      ST_SEND: begin
        if (bit_cnt == LAST_BIT) begin
          bit_n = 4'd0;
          if (frame_cnt == LAST_FRAME) begin
            frame_n = 4'd0;
            gap_n   = '0;
            state_n = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
          end else begin
            frame_n = frame_cnt + 4'd1;
          end
        end else begin
          bit_n = bit_cnt + 4'd1;
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          state_n = ST_IDLE;
          gap_n   = '0;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // sout is registered: select the bit that the next-state counters point at.
    case (frame_n)
      4'd0:    data_v = b_q[31:24];
      4'd1:    data_v = b_q[23:16];
      4'd2:    data_v = b_q[15:8];
      4'd3:    data_v = b_q[7:0];
      4'd4:    data_v = a_q[31:24];
      4'd5:    data_v = a_q[23:16];
      4'd6:    data_v = a_q[15:8];
      4'd7:    data_v = a_q[7:0];
      default: data_v = cmd_payload;
    endcase

    if (state_n == ST_SEND) begin
      if (bit_n == 4'd0)
        sout_n = 1'b0;
      else if (bit_n == 4'd1)
        sout_n = (frame_n == LAST_FRAME) ? FRAME_CMD : FRAME_DATA;
      else if (bit_n == LAST_BIT)
        sout_n = 1'b1;
      else
        sout_n = data_v[3'(4'd9 - bit_n)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      frame_cnt <= 4'd0;
      bit_cnt   <= 4'd0;
      gap_cnt   <= '0;
      sout      <= 1'b1;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      op_q      <= OP_AND;
      inj_q     <= 1'b0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_n;
      bit_cnt   <= bit_n;
      gap_cnt   <= gap_n;
      sout      <= sout_n;
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        op_q  <= alu_op_t'(op);
        inj_q <= crc_err_inj;
      end
    end
  end

endmodule
